// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Definitions shared by the scroll display controller and its sub-blocks:
//   - MODE_* : encodings of the 2-bit MODE input
//   - blank_code()  : all-ones BLANK character code for a given code width
//   - digit_index() : message slot shown on a digit, (digit - pos) mod ring
// -----------------------------------------------------------------------------
package display_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO_L = 2'b01;
    localparam logic [1:0] MODE_AUTO_R = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Returns a 32-bit mask with the low char_w bits set; callers slice it
    // down to their own code width.
    function automatic logic [31:0] blank_code(input int unsigned char_w);
        logic [31:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < char_w) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    // Ring slot k displayed on a digit: k = (digit - pos) mod num_digits.
    // num_digits is added first so the subtraction never goes negative.
    function automatic int unsigned digit_index(input int unsigned digit,
                                                input int unsigned pos,
                                                input int unsigned num_digits);
        return (digit + num_digits - pos) % num_digits;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Divides the clock by TICK_DIV while enabled and flags the last cycle of each
// period with a combinational single-cycle tick.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, count to 0
//   en      : count enable; when low the count is cleared and no tick fires
//   restart : synchronous clear; the current cycle counts as the first of a
//             fresh period, so a full period is exactly TICK_DIV enabled cycles
//   tick    : high on the last cycle of a period (every cycle if TICK_DIV = 1)
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] base;

    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        base = restart ? '0 : cnt;
        tick = en && (base == CNT_LAST);
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || base == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= base + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scroll_display_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_display_ctrl
// Rotates a message of NUM_CHARS codes around a ring of NUM_DIGITS display
// digits (unused slots BLANK). Rotation follows POS_IN (manual), steps
// left/right once per TICK_DIV cycles (auto), or freezes (hold).
// Ports:
//   CLOCK_50 : clock, all state on rising edge
//   RESET    : synchronous active-high reset, priority over everything
//   CHARS_IN : message, char i at [i*CHAR_W +: CHAR_W]
//   LOAD     : one-cycle strobe, latch CHARS_IN and return to position 0
//   MODE     : 00 manual, 01 auto left, 10 auto right, 11 hold
//   POS_IN   : manual rotation position (ignored if >= NUM_DIGITS)
//   DIGITS   : registered code per digit, digit d at [d*CHAR_W +: CHAR_W]
//   POS_OUT  : registered current rotation position
//   STEP     : one-cycle pulse, aligned with POS_OUT showing an auto step
// -----------------------------------------------------------------------------
module scroll_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_CHARS  = 5,
    parameter int CHAR_W     = 3,
    parameter int TICK_DIV   = 50_000_000,
    localparam int POS_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET,
    input  logic [NUM_CHARS*CHAR_W-1:0]    CHARS_IN,
    input  logic                           LOAD,
    input  logic [1:0]                     MODE,
    input  logic [POS_W-1:0]               POS_IN,
    output logic [NUM_DIGITS*CHAR_W-1:0]   DIGITS,
    output logic [POS_W-1:0]               POS_OUT,
    output logic                           STEP
);

    localparam logic [31:0]       BLANK_FULL = blank_code(CHAR_W);
    localparam logic [CHAR_W-1:0] BLANK      = BLANK_FULL[CHAR_W-1:0];
    localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(NUM_DIGITS - 1);

    logic [CHAR_W-1:0]            char_buf [NUM_CHARS];
    logic [POS_W-1:0]             pos;
    logic [1:0]                   mode_prev;
    logic                         is_auto;
    logic                         tick_en;
    logic                         mode_changed;
    logic                         tick;
    logic                         pos_in_ok;
    logic                         step_pend;
    logic [NUM_DIGITS*CHAR_W-1:0] digits_next;

    assign is_auto      = (MODE == MODE_AUTO_L) || (MODE == MODE_AUTO_R);
    // LOAD clears the count and swallows a same-cycle tick.
    assign tick_en      = is_auto && !LOAD;
    assign mode_changed = (MODE != mode_prev);
    assign pos_in_ok    = (32'(POS_IN) < NUM_DIGITS);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (CLOCK_50),
        .rst    (RESET),
        .en     (tick_en),
        .restart(mode_changed),
        .tick   (tick)
    );

    // Rotation state. mode_prev lets a mode change restart the tick period.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            // NOTE: the message buffer is a handful of flops that must come up
            // showing BLANK, so it is reset explicitly like any other state.
            for (int c = 0; c < NUM_CHARS; c++) char_buf[c] <= BLANK;
            pos       <= '0;
            mode_prev <= MODE_MANUAL;
            step_pend <= 1'b0;
        end else begin
            mode_prev <= MODE;
            step_pend <= tick;
            if (LOAD) begin
                for (int c = 0; c < NUM_CHARS; c++) begin
                    char_buf[c] <= CHARS_IN[c*CHAR_W +: CHAR_W];
                end
                pos <= '0;
            end else begin
                case (MODE)
                    MODE_MANUAL: if (pos_in_ok) pos <= POS_IN;
                    MODE_AUTO_L: if (tick) pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
                    MODE_AUTO_R: if (tick) pos <= (pos == '0) ? POS_LAST : pos - POS_W'(1);
                    default:     ;
                endcase
            end
        end
    end

    // Digit d shows char k = (d - pos) mod NUM_DIGITS when k names a message
    // character, otherwise BLANK.
    always_comb begin
        digits_next = {NUM_DIGITS{BLANK}};
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            for (int unsigned c = 0; c < NUM_CHARS; c++) begin
                if (digit_index(d, 32'(pos), NUM_DIGITS) == c) begin
                    digits_next[d*CHAR_W +: CHAR_W] = char_buf[c];
                end
            end
        end
    end

    // Output registers. STEP is delayed one stage so it appears in the same
    // cycle as the POS_OUT value that the step produced.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            DIGITS  <= {NUM_DIGITS{BLANK}};
            POS_OUT <= '0;
            STEP    <= 1'b0;
        end else begin
            DIGITS  <= digits_next;
            POS_OUT <= pos;
            STEP    <= step_pend;
        end
    end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scroll_display_ctrl
// Self-checking bench for scroll_display_ctrl with NUM_DIGITS=8, NUM_CHARS=5,
// CHAR_W=3, TICK_DIV=4. A constant vector table covers reset and manual
// mapping, hand sequences cover auto wrap, LOAD/tick collision, hold and reset
// mid-scroll, and a random phase is compared cycle by cycle to a reference
// model built from the display rules (ring of slots, elapsed-cycle counting).
// -----------------------------------------------------------------------------
module tb_scroll_display_ctrl;

    localparam int ND = 8;
    localparam int NC = 5;
    localparam int CW = 3;
    localparam int TD = 4;
    localparam int PW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             load;
    logic [NC*CW-1:0] chars_in;
    logic [1:0]       mode;
    logic [PW-1:0]    pos_in;
    logic [ND*CW-1:0] digits;
    logic [PW-1:0]    pos_out;
    logic             step;

    scroll_display_ctrl #(
        .NUM_DIGITS(ND),
        .NUM_CHARS (NC),
        .CHAR_W    (CW),
        .TICK_DIV  (TD)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (reset),
        .CHARS_IN(chars_in),
        .LOAD    (load),
        .MODE    (mode),
        .POS_IN  (pos_in),
        .DIGITS  (digits),
        .POS_OUT (pos_out),
        .STEP    (step)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int               m_buf [NC];
    int               m_pos;
    int               m_elapsed;    // cycles spent in the current auto period
    int               m_prev_mode;
    bit               m_moved;      // last edge produced an auto step
    logic [ND*CW-1:0] e_digits;
    int               e_pos;
    bit               e_step;

    function automatic logic [ND*CW-1:0] render(int p);
        int ring [ND];
        logic [ND*CW-1:0] r;
        for (int k = 0; k < ND; k++) ring[k] = (k < NC) ? m_buf[k] : 7;
        for (int d = 0; d < ND; d++) r[d*CW +: CW] = 3'(ring[(d - p + ND) % ND]);
        return r;
    endfunction

    task automatic model_update();
        if (reset) begin
            for (int k = 0; k < NC; k++) m_buf[k] = 7;
            m_pos = 0; m_elapsed = 0; m_prev_mode = 0; m_moved = 0;
            e_digits = '1; e_pos = 0; e_step = 0;
        end else begin
            // outputs show the state as it was before this edge
            e_digits = render(m_pos);
            e_pos    = m_pos;
            e_step   = m_moved;
            m_moved  = 0;
            if (load) begin
                for (int k = 0; k < NC; k++) m_buf[k] = int'(chars_in[k*CW +: CW]);
                m_pos = 0;
                m_elapsed = 0;
            end else if (mode == 2'b01 || mode == 2'b10) begin
                m_elapsed = (int'(mode) != m_prev_mode) ? 1 : m_elapsed + 1;
                if (m_elapsed == TD) begin
                    m_elapsed = 0;
                    m_pos = (mode == 2'b01) ? (m_pos + 1) % ND : (m_pos + ND - 1) % ND;
                    m_moved = 1;
                end
            end else begin
                m_elapsed = 0;
                if (mode == 2'b00 && int'(pos_in) < ND) m_pos = int'(pos_in);
            end
            m_prev_mode = int'(mode);
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string tag, logic [ND*CW-1:0] xd, int xp, bit xs);
        vectors++;
        if (digits !== xd || int'(pos_out) != xp || step !== xs) begin
            miscompares++;
            $display("FAIL %s: DIGITS=%o POS_OUT=%0d STEP=%0b, want DIGITS=%o POS_OUT=%0d STEP=%0b",
                     tag, digits, pos_out, step, xd, xp, xs);
        end
    endtask

    task automatic check_val(string tag, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic timeout(string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not seen within cycle budget", tag);
    endtask

    task automatic apply(bit r, bit l, logic [NC*CW-1:0] c, logic [1:0] m, logic [PW-1:0] p);
        reset = r; load = l; chars_in = c; mode = m; pos_in = p;
    endtask

    // One clock: model follows the DUT edge, outputs sampled 1 time unit later.
    task automatic step_clk();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_checked(int n, string tag);
        for (int i = 0; i < n; i++) begin
            step_clk();
            check(tag, e_digits, e_pos, e_step);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit               rst;
        bit               ld;
        logic [NC*CW-1:0] chars;
        logic [1:0]       md;
        logic [PW-1:0]    pin;
        logic [ND*CW-1:0] x_digits;
        int               x_pos;
        bit               x_step;
    } vec_t;

    vec_t tv [13];

    initial begin
        int steps;
        int exp_p;
        int first;
        int pos_at;
        bit found;
        logic [ND*CW-1:0] held;

        // Outputs trail inputs by two edges, so each row's expectation
        // reflects the inputs of the row before it.
        tv[0]  = '{1'b1, 1'b1, 15'o12345, 2'b01, 3'd5, 24'o77777777, 0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 15'o54321, 2'b10, 3'd2, 24'o77777777, 0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 15'o43210, 2'b00, 3'd0, 24'o77777777, 0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd0, 24'o77743210, 0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd6, 24'o77743210, 0, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd6, 24'o10777432, 6, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 15'o00000, 2'b11, 3'd2, 24'o10777432, 6, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 15'o00000, 2'b11, 3'd1, 24'o10777432, 6, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd3, 24'o10777432, 6, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd3, 24'o43210777, 3, 1'b0};
        tv[10] = '{1'b0, 1'b1, 15'o70605, 2'b00, 3'd3, 24'o43210777, 3, 1'b0};
        tv[11] = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd1, 24'o77770605, 0, 1'b0};
        tv[12] = '{1'b0, 1'b0, 15'o00000, 2'b00, 3'd1, 24'o77706057, 1, 1'b0};

        apply(1'b1, 1'b0, '0, 2'b00, '0);
        for (int i = 0; i < 13; i++) begin
            apply(tv[i].rst, tv[i].ld, tv[i].chars, tv[i].md, tv[i].pin);
            step_clk();
            check($sformatf("table[%0d]", i), tv[i].x_digits, tv[i].x_pos, tv[i].x_step);
        end

        // Auto-left: 8 steps wrap POS_OUT 1..7,0 and char 0 returns to digit 0.
        apply(1'b0, 1'b1, 15'o43210, 2'b00, 3'd0);
        run_checked(1, "A_load");
        apply(1'b0, 1'b0, 15'o43210, 2'b01, 3'd0);
        steps = 0;
        exp_p = 0;
        for (int i = 0; i < 34; i++) begin
            step_clk();
            check("A_auto_left", e_digits, e_pos, e_step);
            if (step) begin
                steps++;
                exp_p = (exp_p + 1) % ND;
                check_val("A_step_pos", int'(pos_out), exp_p);
            end
        end
        check_val("A_step_count", steps, 8);
        check_val("A_pos_wrapped", int'(pos_out), 0);
        check_val("A_digit0", int'(digits[2:0]), 0);

        // Auto-right from pos 0: first step lands on 7 with char 0 on digit 7.
        apply(1'b0, 1'b1, 15'o43210, 2'b00, 3'd0);
        run_checked(1, "B_load");
        apply(1'b0, 1'b0, 15'o43210, 2'b10, 3'd0);
        found = 0;
        for (int j = 1; j <= 10 && !found; j++) begin
            step_clk();
            check("B_auto_right", e_digits, e_pos, e_step);
            if (step) begin
                found = 1;
                check_val("B_first_step_cycle", j, TD + 1);
                check_val("B_pos", int'(pos_out), 7);
                check_val("B_digit7", int'(digits[21 +: 3]), 0);
            end
        end
        if (!found) timeout("B_step");

        // LOAD on the cycle a tick is due: no STEP, pos back to 0, next step
        // updates pos 4 edges after LOAD and shows on the 5th observation.
        apply(1'b0, 1'b1, 15'o43210, 2'b00, 3'd0);
        run_checked(1, "C_load");
        apply(1'b0, 1'b0, 15'o43210, 2'b01, 3'd0);
        run_checked(3, "C_count");
        apply(1'b0, 1'b1, 15'o01234, 2'b01, 3'd0);
        run_checked(1, "C_collide");
        apply(1'b0, 1'b0, 15'o01234, 2'b01, 3'd0);
        first = 0;
        pos_at = -1;
        for (int j = 1; j <= 8; j++) begin
            step_clk();
            check("C_after", e_digits, e_pos, e_step);
            if (step && first == 0) begin
                first = j;
                pos_at = int'(pos_out);
            end
        end
        check_val("C_first_step", first, TD + 1);
        check_val("C_pos_after_step", pos_at, 1);

        // HOLD at pos 3 for 20 cycles while POS_IN wanders.
        apply(1'b0, 1'b0, 15'o01234, 2'b00, 3'd3);
        run_checked(3, "D_manual");
        held = digits;
        steps = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b0, 15'($urandom), 2'b11, 3'($urandom));
            step_clk();
            check("D_hold", e_digits, e_pos, e_step);
            if (step) steps++;
            if (digits !== held) check_val("D_hold_digits", int'(digits), int'(held));
        end
        check_val("D_hold_steps", steps, 0);
        check_val("D_hold_pos", int'(pos_out), 3);

        // RESET while scrolling left at pos 5.
        apply(1'b0, 1'b1, 15'o43210, 2'b00, 3'd0);
        run_checked(1, "E_load");
        apply(1'b0, 1'b0, 15'o43210, 2'b01, 3'd0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step_clk();
            check("E_scroll", e_digits, e_pos, e_step);
            if (pos_out == 3'd5) found = 1;
        end
        if (!found) timeout("E_reach_pos5");
        apply(1'b1, 1'b0, 15'o43210, 2'b01, 3'd0);
        step_clk();
        check("E_reset", 24'o77777777, 0, 1'b0);
        apply(1'b0, 1'b0, 15'o43210, 2'b01, 3'd0);
        run_checked(8, "E_post_reset");

        // Random phase: sticky modes, occasional LOAD and RESET.
        apply(1'b0, 1'b0, 15'($urandom), 2'($urandom), 3'($urandom));
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 15) == 0);
            chars_in = 15'($urandom);
            pos_in   = 3'($urandom);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            step_clk();
            check("random", e_digits, e_pos, e_step);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scroll_display_ctrl.md
# scroll_display_ctrl

Parametrised character-rotation controller for the HEX display bank. It holds up to NUM_CHARS character codes in a message ring NUM_DIGITS slots long, padded with blank codes. Each cycle it produces one registered code per display digit. Rotation is selected by switch position (manual) or stepped automatically left/right on a divided-clock tick. Its packed output feeds one existing `char_7seg` decoder per digit at the top level.

## Interface
Parameters:
- NUM_DIGITS, 8, number of display digits; ring length
- NUM_CHARS, 5, message characters; must satisfy 1 ≤ NUM_CHARS ≤ NUM_DIGITS
- CHAR_W, 3, bits per character code; code all-ones = BLANK
- TICK_DIV, 50_000_000, clock cycles per auto-scroll step; ≥ 1
- POS_W, $clog2(NUM_DIGITS) (minimum 1), position width; derived, not overridden

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge
- RESET  in  1  synchronous, active-high reset
- CHARS_IN  in  NUM_CHARS*CHAR_W  message; char i at [i*CHAR_W +: CHAR_W]
- LOAD  in  1  single-cycle strobe; latch CHARS_IN
- MODE  in  2  00 MANUAL, 01 AUTO_LEFT, 10 AUTO_RIGHT, 11 HOLD
- POS_IN  in  POS_W  manual rotation position
- DIGITS  out  NUM_DIGITS*CHAR_W  digit d code at [d*CHAR_W +: CHAR_W]; digit 0 = HEX0
- POS_OUT  out  POS_W  current rotation position, to LEDs
- STEP  out  1  one-cycle pulse when an auto tick moves pos

## Operation
- State: char buffer `buf[NUM_CHARS]`, `pos` in 0..NUM_DIGITS-1, tick counter `cnt` in 0..TICK_DIV-1.
- Mapping: digit d shows `buf[k]` when k < NUM_CHARS, where k = (d − pos) mod NUM_DIGITS; otherwise BLANK. At pos 0, char 0 is on digit 0 and char NUM_CHARS-1 is on digit NUM_CHARS-1. Increasing pos moves the message toward higher digits.
- MANUAL: pos ← POS_IN each cycle. If POS_IN ≥ NUM_DIGITS, pos holds. cnt held at 0.
- AUTO_LEFT: cnt increments each cycle. When cnt = TICK_DIV-1: cnt ← 0, pos ← pos+1 (NUM_DIGITS-1 wraps to 0), STEP = 1.
- AUTO_RIGHT: same counting, but pos ← pos−1 (0 wraps to NUM_DIGITS-1).
- HOLD: pos and buf frozen; cnt held at 0.
- Any MODE change clears cnt. The first auto step therefore occurs TICK_DIV cycles after entering an auto mode.
- LOAD (any mode): buf ← CHARS_IN, pos ← 0, cnt ← 0. This overrides a same-cycle tick or a same-cycle MANUAL update; no STEP is issued that cycle.
- Characters equal to BLANK in CHARS_IN display as blank; no special handling.
- RESET (priority over all): buf all BLANK, pos 0, cnt 0, STEP 0, DIGITS all BLANK, POS_OUT 0. Reset mid-scroll discards the partial count.

## Timing
- Edge k: pos/buf/cnt update. Edge k+1: DIGITS and POS_OUT registered from the new state. Latency from input to display is 2 cycles: POS_IN → DIGITS, LOAD → DIGITS.
- STEP is registered and asserted in the cycle after the edge that updated pos. It aligns with POS_OUT changing.
- Auto period is exactly TICK_DIV cycles per step. With TICK_DIV=1, pos steps every cycle and STEP stays high.
- All outputs are glitch-free registers; no combinational path from inputs to outputs.

## Structure
- Shared package `display_pkg`: MODE encodings (MODE_MANUAL, MODE_AUTO_L, MODE_AUTO_R, MODE_HOLD), BLANK function of CHAR_W (all ones), and the function computing the modulo digit index.
- Sub-module `tick_gen`: parametrised TICK_DIV counter with synchronous clear input and single-cycle `tick` output. The top of this block instantiates it; mapping and mode logic stay inline.
- Top-level board wrapper instantiates NUM_DIGITS `char_7seg` decoders on DIGITS slices.

## Test plan
All scenarios use NUM_DIGITS=8, NUM_CHARS=5, CHAR_W=3, TICK_DIV=4.
- Reset: assert RESET 2 cycles with arbitrary inputs → DIGITS = all 3'b111, POS_OUT=0, STEP=0.
- Load + manual: CHARS_IN={4,3,2,1,0} (char0=0), LOAD pulse, MODE=00, POS_IN=0 → 2 cycles later, digits 0..4 = 0,1,2,3,4 and digits 5..7 = BLANK. Set POS_IN=6 → digit 6=0, digit 7=1, digit 0=2, digit 1=3, digit 2=4, digits 3..5 BLANK.
- Auto-left wrap: after load, MODE=01 → STEP every 4 cycles; POS_OUT 0→1→…→7→0. Digit 0 shows 0 again after 32 cycles.
- Auto-right wrap: from pos 0, MODE=10 → first step yields POS_OUT=7 and digit 7 = char 0.
- Collision: LOAD asserted on the cycle cnt=3 in AUTO_LEFT → pos=0, no STEP, next step exactly 4 cycles later.
- HOLD and reset mid-scroll: MODE=11 at pos 3 for 20 cycles → DIGITS unchanged, STEP never asserted. RESET at pos 5 in AUTO_LEFT → all BLANK, POS_OUT=0 next cycle.
